seq_multiplier: RTL and testbench

//  Parametrised sequential (radix-2 shift-and-add) multiplier: WIDTH x WIDTH -> 2*WIDTH.

---
 rtl/seq_multiplier.sv | 125 ++++++++++++
 tb/tb_seq_multiplier.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Radix-2 shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH, signed or unsigned
// per operation. One adder is reused over WIDTH cycles; the sign of a signed result
// is applied once at the end by negating the unsigned magnitude product.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               neg;

    logic               accept;
    logic               last_step;
    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_nxt;

    // Absolute value of an operand; the most negative value maps to 2^(W-1),
    // which still fits in W unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic sgn);
        logic signed [WIDTH-1:0] xs;
        xs = x;
        if (sgn && xs < 0)
            return WIDTH'(-xs);
        return x;
    endfunction

    // Two's complement of the full-width magnitude product, applied when the
    // operand signs differ. Cannot overflow: |result| <= 2^(2W-2).
    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] m,
                                                      input logic n);
        logic signed [2*WIDTH-1:0] ms;
        ms = m;
        if (n)
            return (2*WIDTH)'(-ms);
        return m;
    endfunction

    assign accept    = (state == S_IDLE) && start;
    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign addend    = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
    assign acc_nxt   = acc + addend;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode and handshake outputs; start is ignored outside IDLE.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start)
                    state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_step)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, shift-and-add iteration, and result load on the final step
    // so that product is already valid during the single DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (accept) begin
            mcand   <= magnitude(a, is_signed);
            mplier  <= magnitude(b, is_signed);
            neg     <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc     <= '0;
            cnt     <= '0;
        end else if (state == S_RUN) begin
            acc    <= acc_nxt;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last_step)
                product <= apply_sign(acc_nxt, neg);
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed table for WIDTH=8, handshake
// and async-reset sequences, a WIDTH=4 instance, and random operands compared
// against a plain integer-arithmetic reference.
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        start, is_signed;
    logic [7:0]  a, b;
    logic        ready, busy, done;
    logic [15:0] product;

    logic        start4, sgn4;
    logic [3:0]  a4, b4;
    logic        ready4, busy4, done4;
    logic [7:0]  product4;

    int total = 0;
    int bad   = 0;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .ready(ready), .busy(busy), .done(done), .product(product)
    );

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .is_signed(sgn4),
        .a(a4), .b(b4), .ready(ready4), .busy(busy4), .done(done4), .product(product4)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: interpret operands as integers, multiply, keep 2*w low bits.
    function automatic logic [31:0] ref_mul(input int w, input logic sgn,
                                            input logic [7:0] av, input logic [7:0] bv);
        longint x, y, p, mask;
        x = longint'(av);
        y = longint'(bv);
        if (sgn && av[w-1]) x = x - (longint'(1) << w);
        if (sgn && bv[w-1]) y = y - (longint'(1) << w);
        p    = x * y;
        mask = (longint'(1) << (2 * w)) - 1;
        return 32'(p & mask);
    endfunction

    // One operation on the 8-bit instance; operands are scrambled right after
    // acceptance, and product must hold its old value until done.
    task automatic run8(input logic sgn, input logic [7:0] av, input logic [7:0] bv,
                        output logic [15:0] res);
        int n;
        logic held;
        logic [15:0] prevp;
        @(negedge clk);
        is_signed = sgn; a = av; b = bv; start = 1'b1;
        prevp = product;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); is_signed = 1'($urandom);
        chk("accept8", {30'd0, ready, busy}, 32'b01);
        n = 0;
        held = 1'b1;
        while (done !== 1'b1 && n < 40) begin
            if (product !== prevp) held = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        chk("done8_seen", {31'd0, done}, 32'd1);
        chk("hold8", {31'd0, held}, 32'd1);
        res = product;
        @(posedge clk); #1;
        chk("pulse8", {29'd0, done, ready, busy}, 32'b010);
    endtask

    task automatic run4(input logic sgn, input logic [3:0] av, input logic [3:0] bv,
                        output logic [7:0] res);
        int n;
        @(negedge clk);
        sgn4 = sgn; a4 = av; b4 = bv; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); sgn4 = 1'($urandom);
        n = 0;
        while (done4 !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done4_seen", {31'd0, done4}, 32'd1);
        res = product4;
        @(posedge clk); #1;
        chk("pulse4", {31'd0, done4}, 32'd0);
    endtask

    typedef struct {
        logic        sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [15:0] r8;
        logic [7:0]  r4;
        logic [7:0]  ra, rb;
        logic        rs;
        int acc_cnt, dcnt, last_d, gap_bad, prod_bad, late_done;

        vecs[0] = '{1'b0, 8'd9,   8'd8,   16'h0048};
        vecs[1] = '{1'b0, 8'd8,   8'd9,   16'h0048};
        vecs[2] = '{1'b0, 8'd255, 8'd255, 16'hFE01};
        vecs[3] = '{1'b0, 8'd0,   8'd200, 16'h0000};
        vecs[4] = '{1'b1, 8'hFD,  8'h05,  16'hFFF1};
        vecs[5] = '{1'b1, 8'h80,  8'h80,  16'h4000};
        vecs[6] = '{1'b1, 8'h80,  8'h7F,  16'hC080};
        vecs[7] = '{1'b0, 8'hFD,  8'h05,  16'h04F1};
        vecs[8] = '{1'b1, 8'h05,  8'hFD,  16'hFFF1};

        reset = 1'b1;
        start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_product", {16'd0, product}, 32'd0);
        chk("rst_product4", {24'd0, product4}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run8(vecs[i].sgn, vecs[i].a, vecs[i].b, r8);
            chk($sformatf("vec%0d", i), {16'd0, r8}, {16'd0, vecs[i].exp});
        end

        // start held high: accepted only in IDLE, one op per 10 cycles
        @(negedge clk);
        a = 8'd3; b = 8'd4; is_signed = 1'b0; start = 1'b1;
        acc_cnt = 0; dcnt = 0; last_d = -100; gap_bad = 0; prod_bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (ready) acc_cnt++;
            @(posedge clk); #1;
            if (done) begin
                dcnt++;
                if (last_d >= 0 && i - last_d != 10) gap_bad++;
                if (product !== 16'd12) prod_bad++;
                last_d = i;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("hs_accepts", acc_cnt, 32'd3);
        chk("hs_dones", dcnt, 32'd3);
        chk("hs_spacing", gap_bad, 32'd0);
        chk("hs_product", prod_bad, 32'd0);
        repeat (12) @(posedge clk);

        // Async reset in the middle of an operation
        @(negedge clk);
        a = 8'd9; b = 8'd8; is_signed = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_ready", {31'd0, ready}, 32'd1);
        chk("arst_busy",  {31'd0, busy},  32'd0);
        chk("arst_done",  {31'd0, done},  32'd0);
        chk("arst_product", {16'd0, product}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        late_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) late_done++;
        end
        chk("arst_no_done", late_done, 32'd0);
        run8(1'b0, 8'd7, 8'd6, r8);
        chk("after_rst", {16'd0, r8}, 32'd42);

        // Narrow instance corners
        run4(1'b0, 4'd15, 4'd15, r4);
        chk("w4_15x15", {24'd0, r4}, 32'd225);
        run4(1'b1, 4'h8, 4'h8, r4);
        chk("w4_m8xm8", {24'd0, r4}, 32'd64);
        run4(1'b1, 4'h8, 4'h7, r4);
        chk("w4_m8x7", {24'd0, r4}, 32'hC8);

        // Random operands
        for (int i = 0; i < 120; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            run8(rs, ra, rb, r8);
            chk($sformatf("rnd8 s=%0d %0h*%0h", rs, ra, rb), {16'd0, r8},
                ref_mul(8, rs, ra, rb));
        end
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 15)); rb = 8'($urandom_range(0, 15)); rs = 1'($urandom);
            run4(rs, ra[3:0], rb[3:0], r4);
            chk($sformatf("rnd4 s=%0d %0h*%0h", rs, ra, rb), {24'd0, r4},
                ref_mul(4, rs, ra, rb));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
